// File: rtl/uart_mmio_pkg.sv
// Register offsets and STATUS/CTRL field layout shared by the UART MMIO bridge.
package uart_mmio_pkg;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int STATUS_TX_DROP = 2;
  localparam int CTRL_RX_IRQ_EN = 0;

  // Member order puts tx_not_full at bit 0 and tx_empty at bit 3.
  typedef struct packed {
    logic tx_empty;
    logic tx_drop;
    logic rx_not_empty;
    logic tx_not_full;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART controller: CPU register window over a TX FIFO and an RX FIFO
// feeding the uart's valid/ready byte ports.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic              i_we,
  input  logic              i_re,
  output logic [XLEN-1:0]   o_rdata,
  output logic [7:0]        o_data_in,
  output logic              o_data_in_valid,
  input  logic              i_data_in_ready,
  input  logic [7:0]        i_data_out,
  input  logic              i_data_out_valid,
  output logic              o_data_out_ready,
  output logic              o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]      tx_head;
  logic [CW-1:0]   tx_count;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]      rx_head;
  logic [CW-1:0]   rx_count;
  logic            tx_drop;
  logic            rx_irq_en;
  logic [3:0]      word_off;
  logic            mapped;
  logic            sel_status, sel_rxdata, sel_txdata, sel_ctrl;
  status_t         status;
  logic [XLEN-1:0] rdata_next;
  logic            unused_bits;

  assign word_off   = {i_addr[3:2], 2'b00};
  assign mapped     = ((i_addr >> 4) == '0);
  assign sel_status = mapped && (word_off == OFF_STATUS);
  assign sel_rxdata = mapped && (word_off == OFF_RXDATA);
  assign sel_txdata = mapped && (word_off == OFF_TXDATA);
  assign sel_ctrl   = mapped && (word_off == OFF_CTRL);

  // Valid/ready on the uart side: a byte moves on any cycle where valid and ready
  // are both high; valid never waits for ready, and ready is low only while RX is full.
  assign tx_push = i_we && sel_txdata && !tx_full;
  assign tx_pop  = o_data_in_valid && i_data_in_ready;
  assign rx_push = i_data_out_valid && o_data_out_ready;
  assign rx_pop  = i_re && sel_rxdata && !rx_empty;

  assign o_data_in        = tx_head;
  assign o_data_in_valid  = !tx_empty;
  assign o_data_out_ready = !rx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (i_wdata[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (i_data_out),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_comb begin
    status              = '0;
    status.tx_not_full  = !tx_full;
    status.rx_not_empty = !rx_empty;
    status.tx_drop      = tx_drop;
    status.tx_empty     = tx_empty;
  end

  // Read mux sees start-of-cycle state, so a same-cycle STATUS write is not reflected.
  always_comb begin
    rdata_next = '0;
    if (sel_status) begin
      rdata_next = XLEN'(status);
    end else if (sel_rxdata && !rx_empty) begin
      rdata_next = XLEN'(rx_head);
    end else if (sel_ctrl) begin
      rdata_next[CTRL_RX_IRQ_EN] = rx_irq_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rdata   <= '0;
      tx_drop   <= 1'b0;
      rx_irq_en <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      if (i_re) o_rdata <= rdata_next;
      if (i_we && sel_txdata && tx_full) begin
        tx_drop <= 1'b1;
      end else if (i_we && sel_status && i_wdata[STATUS_TX_DROP]) begin
        tx_drop <= 1'b0;
      end
      if (i_we && sel_ctrl) rx_irq_en <= i_wdata[CTRL_RX_IRQ_EN];
      o_irq <= rx_irq_en && !rx_empty;
    end
  end

  assign unused_bits = ^{i_wdata[XLEN-1:8], i_addr[1:0], tx_count, rx_count};

endmodule
